// File: rtl/data_memory.sv
// data_memory: block-level backing store behind the data cache.
// Serves 128-bit (4-word) blocks with a fixed LATENCY-cycle service time and
// a busy-wait handshake (IDLE -> BUSY -> DONE -> IDLE).
module data_memory #(
  parameter int unsigned DEPTH_BLOCKS = 256,
  parameter int unsigned LATENCY      = 5
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         MEM_READ,
  input  logic         MEM_WRITE,
  input  logic [27:0]  MEM_BLOCK_ADDR,
  input  logic [127:0] MEM_WRITEDATA,
  output logic [127:0] MEM_READDATA,
  output logic         MEM_BUSYWAIT
);

  localparam int unsigned IDX_W = (DEPTH_BLOCKS > 1) ? $clog2(DEPTH_BLOCKS) : 1;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_count;
  logic               r_op_write;
  logic [IDX_W-1:0]   r_idx;
  logic [127:0]       r_wdata;

  // Contents and read register start at zero and are deliberately not
  // touched by RESET: a reset aborts the access in flight but leaves stored
  // blocks and the last returned block intact.
  logic [127:0]       r_readdata = '0;
  logic [127:0]       r_mem [DEPTH_BLOCKS] = '{default: '0};

  logic               w_req;
  logic [IDX_W-1:0]   w_idx;
  logic               w_accept;
  logic               w_last;
  logic               w_unused_addr;

  assign w_req    = MEM_READ | MEM_WRITE;
  assign w_idx    = MEM_BLOCK_ADDR[IDX_W-1:0];
  assign w_accept = (r_state == S_IDLE) && w_req;
  assign w_last   = (r_state == S_BUSY) && (r_count == '0);

  // Upper address bits beyond the array size are ignored (address wraps).
  assign w_unused_addr = ^(MEM_BLOCK_ADDR >> IDX_W);

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: DONE always returns to IDLE, ignoring held requests.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_req) w_next = S_BUSY;
      S_BUSY: if (r_count == '0) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Busy-wait output: combinational so it rises with the request itself.
  always_comb begin
    MEM_BUSYWAIT = 1'b0;
    if (!RESET) begin
      unique case (r_state)
        S_IDLE:  MEM_BUSYWAIT = w_req;
        S_BUSY:  MEM_BUSYWAIT = 1'b1;
        S_DONE:  MEM_BUSYWAIT = 1'b0;
        default: MEM_BUSYWAIT = 1'b0;
      endcase
    end
  end

  // Latch the request at acceptance (write wins over read) and run the
  // latency countdown while in BUSY.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count    <= CNT_INIT;
      r_op_write <= MEM_WRITE;
      r_idx      <= w_idx;
      r_wdata    <= MEM_WRITEDATA;
    end else if ((r_state == S_BUSY) && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Commit a latched write on the last BUSY edge.
  always_ff @(posedge CLK) begin
    if (!RESET && w_last && r_op_write) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  // Capture read data on the last BUSY edge; held until the next read.
  always_ff @(posedge CLK) begin
    if (!RESET && w_last && !r_op_write) begin
      r_readdata <= r_mem[r_idx];
    end
  end

  assign MEM_READDATA = r_readdata;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: two instances (LATENCY 5 / depth 256 and
// LATENCY 1 / depth 16) checked every cycle against a transaction-level model.
module tb_data_memory;

  localparam int LAT [2] = '{5, 1};
  localparam int DEP [2] = '{256, 16};

  logic         CLK;
  logic         RESET;
  logic [1:0]   rd;
  logic [1:0]   wr;
  logic [27:0]  addr;
  logic [127:0] wdata;
  logic [127:0] rdata0;
  logic [127:0] rdata1;
  logic [1:0]   busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  data_memory #(.DEPTH_BLOCKS(256), .LATENCY(5)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .MEM_READ(rd[0]), .MEM_WRITE(wr[0]),
    .MEM_BLOCK_ADDR(addr), .MEM_WRITEDATA(wdata),
    .MEM_READDATA(rdata0), .MEM_BUSYWAIT(busy[0])
  );

  data_memory #(.DEPTH_BLOCKS(16), .LATENCY(1)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .MEM_READ(rd[1]), .MEM_WRITE(wr[1]),
    .MEM_BLOCK_ADDR(addr), .MEM_WRITEDATA(wdata),
    .MEM_READDATA(rdata1), .MEM_BUSYWAIT(busy[1])
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rdat(input int d);
    return (d == 0) ? rdata0 : rdata1;
  endfunction

  // Reference model: per instance, edges elapsed since acceptance (-1 = idle),
  // the latched request, the block store and the last read result.
  logic [127:0] m_mem [2][256];
  logic [127:0] m_rd  [2];
  int           m_k   [2];
  bit           m_w   [2];
  int           m_i   [2];
  logic [127:0] m_d   [2];

  // Advance the model across the coming posedge using the inputs that will be
  // present at that edge (inputs only change 1ns after a posedge).
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (RESET) begin
        m_k[d] = -1;
      end else if (m_k[d] < 0) begin
        if (rd[d] || wr[d]) begin
          m_k[d] = 0;
          m_w[d] = wr[d];
          m_i[d] = int'(addr) % DEP[d];
          m_d[d] = wdata;
        end
      end else begin
        m_k[d]++;
        if (m_k[d] == LAT[d]) begin
          if (m_w[d]) m_mem[d][m_i[d]] = m_d[d];
          else        m_rd[d] = m_mem[d][m_i[d]];
        end else if (m_k[d] == LAT[d] + 1) begin
          m_k[d] = -1;
        end
      end
    end
  endtask

  // Compare process: every negedge, check both instances, then step the model.
  initial begin
    bit eb;
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < 256; j++) m_mem[d][j] = '0;
      m_rd[d] = '0;
      m_k[d]  = -1;
      m_w[d]  = 1'b0;
      m_i[d]  = 0;
      m_d[d]  = '0;
    end
    #2;
    model_step();
    forever begin
      @(negedge CLK);
      for (int d = 0; d < 2; d++) begin
        eb = !RESET && ((m_k[d] < 0) ? (rd[d] || wr[d]) : (m_k[d] < LAT[d]));
        chk($sformatf("busy%0d", d), {127'd0, busy[d]}, {127'd0, eb});
        chk($sformatf("rdata%0d", d), rdat(d), m_rd[d]);
      end
      model_step();
    end
  end

  task automatic set_req(input int d, input bit r, input bit w,
                         input logic [27:0] a, input logic [127:0] dat);
    rd[d] = r;
    wr[d] = w;
    addr  = a;
    wdata = dat;
  endtask

  task automatic drop(input int d);
    rd[d] = 1'b0;
    wr[d] = 1'b0;
  endtask

  // Cache-side wait: counts edges with busy high, returns 1ns after the edge
  // at which busy was sampled low, plus that edge's cycle number.
  task automatic wait_rel(input int d, output int n, output int rel);
    bit ok;
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (!busy[d]) begin
        ok = 1'b1;
        break;
      end
      n++;
      @(posedge CLK);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL busy_timeout%0d actual=stuck_high required=release", d);
    end
    @(posedge CLK);
    #1;
    rel = cyc;
  endtask

  task automatic access(input int d, input bit r, input bit w,
                        input logic [27:0] a, input logic [127:0] dat,
                        output int n, output int rel);
    set_req(d, r, w, a, dat);
    wait_rel(d, n, rel);
    drop(d);
  endtask

  localparam logic [127:0] VAL7 = 128'h0000000D_0000000C_0000000B_0000000A;
  localparam logic [127:0] VALX = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] VALA = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] VALB = 128'h55555555_66666666_77777777_88888888;
  localparam logic [127:0] VALY = 128'h0BADF00D_0BADF00D_12345678_9ABCDEF0;
  localparam logic [127:0] VALZ = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
  localparam logic [127:0] VALW = 128'h00000001_00000002_00000003_00000004;

  initial begin
    int n, r1, r2;
    logic [127:0] rw;
    RESET = 1'b1;
    rd    = 2'b01;
    wr    = 2'b00;
    addr  = '0;
    wdata = '0;
    repeat (3) @(posedge CLK);
    #1;
    rd = 2'b00;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    chk("reset_rdata0", rdata0, '0);
    chk("reset_busy0", {127'd0, busy[0]}, '0);

    access(0, 1'b1, 1'b0, 28'd3, '0, n, r1);
    chk("rd3_busy_edges", 128'(n), 128'd6);
    chk("rd3_data", rdata0, '0);

    access(0, 1'b0, 1'b1, 28'd7, VAL7, n, r1);
    chk("wr7_rdata_unchanged", rdata0, '0);
    access(0, 1'b1, 1'b0, 28'd7, '0, n, r1);
    chk("rd7_data", rdata0, VAL7);

    // Write-back then fetch, back to back.
    set_req(0, 1'b0, 1'b1, 28'd2, VALX);
    wait_rel(0, n, r1);
    set_req(0, 1'b1, 1'b0, 28'd9, '0);
    wait_rel(0, n, r2);
    drop(0);
    chk("b2b_spacing", 128'(r2 - r1), 128'd7);
    chk("rd9_data", rdata0, '0);
    access(0, 1'b1, 1'b0, 28'd2, '0, n, r1);
    chk("rd2_data", rdata0, VALX);

    // Reset while a write to block 5 sits at count 2.
    access(0, 1'b0, 1'b1, 28'd5, VALA, n, r1);
    set_req(0, 1'b0, 1'b1, 28'd5, VALB);
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;
    drop(0);
    @(negedge CLK);
    chk("busy_in_reset", {127'd0, busy[0]}, '0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    chk("rdata_kept_reset", rdata0, VALX);
    access(0, 1'b1, 1'b0, 28'd5, '0, n, r1);
    chk("rd5_no_commit", rdata0, VALA);

    // Read and write together: write wins.
    access(0, 1'b1, 1'b0, 28'd7, '0, n, r1);
    access(0, 1'b1, 1'b1, 28'd1, VALY, n, r1);
    chk("dual_rdata_held", rdata0, VAL7);
    access(0, 1'b1, 1'b0, 28'd1, '0, n, r1);
    chk("dual_stored", rdata0, VALY);

    // Address wrap.
    access(0, 1'b0, 1'b1, 28'h0000104, VALZ, n, r1);
    access(0, 1'b1, 1'b0, 28'd4, '0, n, r1);
    chk("wrap_rd4", rdata0, VALZ);

    // LATENCY=1 / depth 16 instance.
    access(1, 1'b0, 1'b1, 28'h0000104, VALW, n, r1);
    chk("lat1_busy_edges", 128'(n), 128'd2);
    access(1, 1'b1, 1'b0, 28'd4, '0, n, r1);
    chk("lat1_wrap_rd4", rdata1, VALW);

    // Randomised traffic, including held/dropped requests and stray resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK);
      #1;
      RESET = ($urandom_range(0, 99) == 0);
      for (int d = 0; d < 2; d++) begin
        rd[d] = ($urandom_range(0, 2) == 0);
        wr[d] = ($urandom_range(0, 3) == 0);
      end
      addr  = 28'($urandom) & 28'hF00003F;
      rw    = {$urandom, $urandom, $urandom, $urandom};
      wdata = rw;
    end
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    rd    = 2'b00;
    wr    = 2'b00;
    repeat (10) @(posedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
